mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Memory-stage access controller that consumes the EX/MEM pipeline register's memory-control outputs and runs each load or store as a multi-cycle req/ack transaction on the data-memory port. While a transaction is in flight it holds `stall_o` high. `stall_o` drives the `stall_i` of every pipeline register, freezing the pipeline until the access completes. Load data is returned to the MEM/WB path on `data_o`.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data word width

Ports:
- `clk_i`  in  1  clock, all state on rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `MemRead_i`  in  1  load request from EX/MEM
- `MemWrite_i`  in  1  store request from EX/MEM
- `addr_i`  in  ADDR_W  byte address (EX/MEM ALU result)
- `data_i`  in  DATA_W  store data (EX/MEM write data)
- `data_o`  out  DATA_W  load result to MEM/WB
- `stall_o`  out  1  pipeline freeze, combinational
- `mem_req_o`  out  1  memory request, registered
- `mem_we_o`  out  1  1 = write, 0 = read, registered
- `mem_addr_o`  out  ADDR_W  word-aligned address, registered
- `mem_wdata_o`  out  DATA_W  write data, registered
- `mem_ack_i`  in  1  memory completion, one-cycle pulse
- `mem_rdata_i`  in  DATA_W  read data, valid with `mem_ack_i`

## Operation
- Request: `req = MemRead_i | MemWrite_i`.
  - Both bits set: treated as a store.
  - For a store, `data_o` is unchanged.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If `req`, latch the following and go to REQ:
    - `mem_addr_o <= {addr_i[ADDR_W-1:2], 2'b00}`
    - `mem_wdata_o <= data_i`
    - `mem_we_o <= MemWrite_i`
    - `mem_req_o <= 1`
  - Otherwise stay in IDLE.
- REQ:
  - Hold all `mem_*_o` stable until `mem_ack_i` is sampled high.
  - On ack: `mem_req_o <= 0`, go to DONE.
  - On a read ack, additionally `rdata_q <= mem_rdata_i`.
- DONE: one cycle, then unconditionally IDLE.
  - The stalled request still sits on the inputs this cycle and is ignored.
  - The pipeline advances at the DONE→IDLE edge.
- `stall_o = (state==IDLE & req) | (state==REQ)`.
  - `stall_o` is 0 in DONE.
- `data_o = rdata_q`, except on a hit (see Configuration).
- `mem_ack_i` while in IDLE or DONE: ignored, no state change.
- Address bits [1:0] are dropped. Sub-word access is not supported.

## Timing
- Reset values (async on `rst_i`=0):
  - state = IDLE
  - `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `rdata_q`=0
  - `stall_o` then follows its equation, i.e. `req` in IDLE.
- Reset mid-transaction:
  - `mem_req_o` drops immediately and the FSM returns to IDLE.
  - The memory side must tolerate the abandoned request.
- Miss latency, with ack in the first REQ cycle:
  - `stall_o` is high for 2 cycles (IDLE + REQ).
  - `data_o` is valid from the DONE cycle onward.
- Ack after k REQ cycles: 1 + k stall cycles.
- Back-to-back accesses: each costs at least 3 cycles, because DONE forces one IDLE cycle before the next request is recognised.
- `data_o` holds its value until the next load completes.

## Configuration
- Macro: `MEM_STAGE_LAST_LOAD_HIT_EN`.
- Defined: adds a one-entry buffer `{valid, tag[ADDR_W-1:2], data}`.
  - A completed load fills the entry and sets `valid`.
  - A completed store whose address matches the tag updates `data`. A non-matching store leaves the entry unchanged.
  - Hit condition: IDLE, `MemRead_i` only, `valid`, and tag == `addr_i[ADDR_W-1:2]`.
  - On a hit: `stall_o`=0, `data_o` = entry data combinationally, no memory transaction, FSM stays IDLE.
  - Reset clears `valid`.
- Undefined: no buffer. Every load takes the full miss path.

## Test plan
- Reset:
  - Assert `rst_i`=0 mid-REQ → `mem_req_o`=0 the same cycle.
  - Release reset → state IDLE, `data_o`=0.
- Load miss:
  - Stimulus: `MemRead_i`=1, `addr_i`=0x0000_0104, ack one cycle after the request with `mem_rdata_i`=0xDEAD_BEEF.
  - Response: `mem_addr_o`=0x104, `mem_we_o`=0, `stall_o` high for exactly 2 cycles, `data_o`=0xDEAD_BEEF in DONE.
- Store with slow memory:
  - Stimulus: `MemWrite_i`=1, `addr_i`=0x0000_0203, `data_i`=0x1234_5678, ack after 4 REQ cycles.
  - Response: `mem_addr_o`=0x200, `mem_wdata_o` stable throughout, `stall_o` high for 5 cycles, `data_o` unchanged.
- Spurious ack: `mem_ack_i` pulsed while in IDLE with no request → no state change, `stall_o`=0.
- Back-to-back: load followed by store → second `mem_req_o` rises exactly 2 cycles after DONE of the first.
- With `MEM_STAGE_LAST_LOAD_HIT_EN`:
  - Load 0x104 (miss), store 0x104 with 0x0000_00AA, then load 0x104.
  - Final load: `stall_o`=0, `data_o`=0x0000_00AA, no `mem_req_o` pulse.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage req/ack access controller with pipeline stall
// Optional one-entry last-load hit buffer: define MEM_STAGE_LAST_LOAD_HIT_EN.
module mem_stage_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] rdata_q;
  logic              req;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              unused_addr_lsb;

  assign req             = MemRead_i | MemWrite_i;
  assign unused_addr_lsb = &{1'b0, addr_i[1:0]};

`ifdef MEM_STAGE_LAST_LOAD_HIT_EN
  logic              buf_valid;
  logic [ADDR_W-3:0] buf_tag;
  logic [DATA_W-1:0] buf_data;

  // A pure load to the last loaded word is served from the buffer without a memory access.
  assign hit      = (state == S_IDLE) & MemRead_i & ~MemWrite_i & buf_valid &
                    (buf_tag == addr_i[ADDR_W-1:2]);
  assign hit_data = buf_data;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == S_REQ && mem_ack_i) begin
      if (!mem_we_o) begin
        buf_valid <= 1'b1;
        buf_tag   <= mem_addr_o[ADDR_W-1:2];
        buf_data  <= mem_rdata_i;
      end else if (buf_tag == mem_addr_o[ADDR_W-1:2]) begin
        buf_data  <= mem_wdata_o;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && !hit) begin
            mem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
            mem_wdata_o <= data_i;
            mem_we_o    <= MemWrite_i;
            mem_req_o   <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            if (!mem_we_o) begin
              rdata_q <= mem_rdata_i;
            end
            state <= S_DONE;
          end
        end
        // The stalled request is still on the inputs here; it must not restart.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall_o = ((state == S_IDLE) & req & ~hit) | (state == S_REQ);
  assign data_o  = hit ? hit_data : rdata_q;

endmodule
